// File: rtl/half_subtractor.sv
// rtl/half_subtractor.sv - registered bitwise half subtractor with valid qualifier
//
// Purpose:
//   WIDTH independent 1-bit lanes. Each lane computes diff = a ^ b and
//   borrow = ~a & b. Results are registered, so there is one clock of latency.
//   Lanes never chain a borrow into each other.
//
// Optional feature (macro HALF_SUBTRACTOR_BORROW_COUNT_EN):
//   Adds a 16-bit saturating count of accepted inputs in which any lane borrowed.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   in_valid     qualifies a/b this cycle
//   a            minuend bits, lane i = a[i]
//   b            subtrahend bits, lane i = b[i]
//   out_valid    diff/borrow/any_borrow hold the result of the previous accepted input
//   diff         registered difference bits
//   borrow       registered borrow-out bits
//   any_borrow   registered OR-reduction of borrow
//   borrow_count (macro only) saturating count of borrowing inputs

module half_subtractor #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] diff,
  output logic [WIDTH-1:0] borrow,
  output logic             any_borrow
`ifdef HALF_SUBTRACTOR_BORROW_COUNT_EN
  ,
  output logic [15:0]      borrow_count
`endif
);

  logic [WIDTH-1:0] borrow_next;
  logic             any_borrow_next;

  always_comb begin
    borrow_next     = ~a & b;
    any_borrow_next = |borrow_next;
  end

  // Data registers only load on accepted inputs, so values (and any X on
  // a/b) are ignored while in_valid is low and the last result is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      diff       <= '0;
      borrow     <= '0;
      any_borrow <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        diff       <= a ^ b;
        borrow     <= borrow_next;
        any_borrow <= any_borrow_next;
      end
    end
  end

`ifdef HALF_SUBTRACTOR_BORROW_COUNT_EN
  // Saturating counter: stops at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      borrow_count <= 16'h0000;
    end else if (in_valid && any_borrow_next && (borrow_count != 16'hFFFF)) begin
      borrow_count <= borrow_count + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_half_subtractor.sv
// tb/tb_half_subtractor.sv - self-checking bench for half_subtractor (WIDTH=1 and WIDTH=4)

module tb_half_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       a1, b1;
  logic [3:0] a4, b4;

  logic       ov1, d1, bw1, ab1;
  logic       ov4, ab4;
  logic [3:0] d4, bw4;
`ifdef HALF_SUBTRACTOR_BORROW_COUNT_EN
  logic [15:0] cnt1, cnt4;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference state
  logic       e_ov;
  logic       e_d1, e_b1, e_ab1;
  logic [3:0] e_d4, e_b4;
  logic       e_ab4;
  int         e_cnt1, e_cnt4;

  always #5 clk = ~clk;

  half_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a1), .b(b1),
    .out_valid(ov1), .diff(d1), .borrow(bw1), .any_borrow(ab1)
`ifdef HALF_SUBTRACTOR_BORROW_COUNT_EN
    , .borrow_count(cnt1)
`endif
  );

  half_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a4), .b(b4),
    .out_valid(ov4), .diff(d4), .borrow(bw4), .any_borrow(ab4)
`ifdef HALF_SUBTRACTOR_BORROW_COUNT_EN
    , .borrow_count(cnt4)
`endif
  );

  // Lane result from plain integer subtraction: difference bit is the
  // result modulo 2, borrow is whether the minuend was smaller.
  task automatic ref_lanes(input int w, input logic [3:0] av, input logic [3:0] bv,
                           output logic [3:0] d, output logic [3:0] bw, output logic any);
    int n;
    d = '0; bw = '0; n = 0;
    for (int i = 0; i < w; i++) begin
      int r;
      r = int'(av[i]) - int'(bv[i]);
      d[i]  = (r % 2) != 0;
      bw[i] = r < 0;
      if (r < 0) n++;
    end
    any = n > 0;
  endtask

  task automatic step(input logic r, input logic v, input logic av1, input logic bv1,
                      input logic [3:0] av4, input logic [3:0] bv4);
    logic [3:0] td, tb;
    logic       tany;
    rst = r; in_valid = v; a1 = av1; b1 = bv1; a4 = av4; b4 = bv4;
    @(posedge clk);
    if (r) begin
      e_ov = 0; e_d1 = 0; e_b1 = 0; e_ab1 = 0;
      e_d4 = 0; e_b4 = 0; e_ab4 = 0; e_cnt1 = 0; e_cnt4 = 0;
    end else begin
      e_ov = v;
      if (v) begin
        ref_lanes(1, {3'b000, av1}, {3'b000, bv1}, td, tb, tany);
        e_d1 = td[0]; e_b1 = tb[0]; e_ab1 = tany;
        if (tany && e_cnt1 < 65535) e_cnt1++;
        ref_lanes(4, av4, bv4, td, tb, tany);
        e_d4 = td; e_b4 = tb; e_ab4 = tany;
        if (tany && e_cnt4 < 65535) e_cnt4++;
      end
    end
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, " ov1"}, 32'(ov1), 32'(e_ov));
    check({tag, " d1"},  32'(d1),  32'(e_d1));
    check({tag, " b1"},  32'(bw1), 32'(e_b1));
    check({tag, " ab1"}, 32'(ab1), 32'(e_ab1));
    check({tag, " ov4"}, 32'(ov4), 32'(e_ov));
    check({tag, " d4"},  32'(d4),  32'(e_d4));
    check({tag, " b4"},  32'(bw4), 32'(e_b4));
    check({tag, " ab4"}, 32'(ab4), 32'(e_ab4));
`ifdef HALF_SUBTRACTOR_BORROW_COUNT_EN
    check({tag, " cnt1"}, 32'(cnt1), 32'(e_cnt1));
    check({tag, " cnt4"}, 32'(cnt4), 32'(e_cnt4));
`endif
  endtask

  initial begin
    // Reset with a live, borrow-free input present: reset must win.
    step(1, 1, 1, 1, 4'hF, 4'hF);
    step(1, 1, 1, 1, 4'hF, 4'hF);
    check_all("reset");
    check("reset_ov_const", 32'(ov1), 32'd0);
    check("reset_d_const",  32'(d4),  32'd0);

    // Exhaustive single lane on back-to-back cycles.
    step(0, 1, 0, 0, 4'h0, 4'h0); check_all("ab00");
    check("ab00_pair", 32'({d1, bw1}), 32'b00);
    step(0, 1, 0, 1, 4'h0, 4'hF); check_all("ab01");
    check("ab01_pair", 32'({d1, bw1}), 32'b11);
    step(0, 1, 1, 0, 4'hF, 4'h0); check_all("ab10");
    check("ab10_pair", 32'({d1, bw1}), 32'b10);
    step(0, 1, 1, 1, 4'hF, 4'hF); check_all("ab11");
    check("ab11_pair", 32'({d1, bw1}), 32'b00);
    check("b2b_valid", 32'(ov1), 32'd1);

    // Hold: result kept when in_valid drops.
    step(0, 1, 0, 1, 4'h1, 4'h2); check_all("hold_load");
    step(0, 0, 1, 1, 4'hF, 4'hF); check_all("hold");
    check("hold_pair", 32'({ov1, d1, bw1}), 32'b011);

    // Multi-lane vector.
    step(0, 1, 0, 0, 4'b1010, 4'b0110); check_all("multi");
    check("multi_vec", 32'({d4, bw4, ab4}), 32'b1100_0100_1);

    // Reset on the same edge as a borrowing input.
    step(1, 1, 0, 1, 4'h0, 4'hF); check_all("mid_rst");
    check("mid_rst_const", 32'({ov1, bw1, bw4}), 32'd0);

    // Randomised traffic with occasional reset.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
           4'($urandom), 4'($urandom));
      check_all("rand");
    end

`ifdef HALF_SUBTRACTOR_BORROW_COUNT_EN
    step(1, 0, 0, 0, 4'h0, 4'h0);
    step(0, 1, 0, 1, 4'h0, 4'h1);
    step(0, 1, 0, 1, 4'h2, 4'h4);
    step(0, 1, 0, 1, 4'h0, 4'h8);
    step(0, 1, 1, 1, 4'hF, 4'h3);
    check_all("cnt3");
    check("cnt3_const", 32'(cnt4), 32'd3);
    for (int i = 0; i < 65534; i++) step(0, 1, 0, 1, 4'h0, 4'h1);
    check_all("cnt_sat");
    check("cnt_sat_const", 32'(cnt4), 32'hFFFF);
    step(0, 1, 0, 1, 4'h0, 4'h1);
    check_all("cnt_sat_hold");
    check("cnt_sat_hold_const", 32'(cnt4), 32'hFFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
